psg_multi: RTL and testbench

- Parametrised successor to the team's 3-channel PSG: N_CH square-tone channels, a shared 17-bit noise LFSR, and a shared 32-step envelope generator.
- Adds per-channel registered 8-bit log-volume outputs, a summed mono mix output and a configurable prescaler.
- Sits on the CPU sound-port bus (BDIR/BC latch protocol) and feeds the audio DAC/mixer.

---
 rtl/psg_multi_if.sv | 11 +
 rtl/psg_multi.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_psg_multi.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psg_multi_if.sv
// psg_multi_if: CPU sound-port bus (BDIR/BC latch protocol) plus the PSG clock enable.
interface psg_multi_if;
  logic       ce;
  logic       bdir;
  logic       bc;
  logic [7:0] di;
  logic [7:0] dout_c;

  modport master (output ce, bdir, bc, di, input dout_c);
  modport slave  (input ce, bdir, bc, di, output dout_c);
endinterface

// File: rtl/psg_multi.sv
// psg_multi: N_CH square-tone channels, shared 17-bit noise LFSR, shared 32-step
// envelope, per-channel registered log volume and a summed mono mix.
// Optional feature macro: PSG_STEREO_EN adds mix_l/mix_r and pan register R17.
module psg_multi #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned PRESCALE = 8,
  parameter int unsigned MIX_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  psg_multi_if.slave        bus,
  output logic [8*N_CH-1:0] ch_out,
  output logic [MIX_W-1:0]  mix,
`ifdef PSG_STEREO_EN
  output logic [MIX_W-1:0]  mix_l,
  output logic [MIX_W-1:0]  mix_r,
`endif
  output logic [N_CH-1:0]   active
);

  localparam int unsigned PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [1:0] ENV_HOLD = 2'd0;
  localparam logic [1:0] ENV_UP   = 2'd1;
  localparam logic [1:0] ENV_DOWN = 2'd2;

  // Wrap limit: period 0 behaves as period 1.
  function automatic logic [15:0] lim(input logic [15:0] p);
    return (p == 16'd0) ? 16'd0 : p - 16'd1;
  endfunction

  // 5-bit volume code to 8-bit log amplitude.
  function automatic logic [7:0] log_vol(input logic [4:0] c);
    logic [7:0] v;
    case (c)
      5'd0:  v = 8'h00;
      5'd1:  v = 8'h01;
      5'd2:  v = 8'h01;
      5'd3:  v = 8'h02;
      5'd4:  v = 8'h02;
      5'd5:  v = 8'h03;
      5'd6:  v = 8'h03;
      5'd7:  v = 8'h04;
      5'd8:  v = 8'h06;
      5'd9:  v = 8'h07;
      5'd10: v = 8'h09;
      5'd11: v = 8'h0A;
      5'd12: v = 8'h0C;
      5'd13: v = 8'h0E;
      5'd14: v = 8'h11;
      5'd15: v = 8'h13;
      5'd16: v = 8'h17;
      5'd17: v = 8'h1B;
      5'd18: v = 8'h20;
      5'd19: v = 8'h25;
      5'd20: v = 8'h2C;
      5'd21: v = 8'h35;
      5'd22: v = 8'h3E;
      5'd23: v = 8'h47;
      5'd24: v = 8'h54;
      5'd25: v = 8'h66;
      5'd26: v = 8'h77;
      5'd27: v = 8'h88;
      5'd28: v = 8'hA1;
      5'd29: v = 8'hC0;
      5'd30: v = 8'hE0;
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

  // Register file and bus state
  logic        bdir_q;
  logic [4:0]  addr;
  logic [11:0] tone_p [N_CH];
  logic [4:0]  vol_r  [N_CH];
  logic [4:0]  noise_p;
  logic [7:0]  mixer;
  logic [15:0] env_p;
  logic [3:0]  env_shape;
  logic        env_pend;
`ifdef PSG_STEREO_EN
  logic [7:0]  pan;
`endif
  logic [7:0]  rd;

  logic rise, latch_stb, wr_stb;
  assign rise      = bus.bdir & ~bdir_q;
  assign latch_stb = rise & bus.bc;
  assign wr_stb    = rise & ~bus.bc;

  // Sound state
  logic [PS_W-1:0] pcnt;
  logic            ntog;
  logic            tick, ntick;
  logic [11:0]     tcnt [N_CH];
  logic [N_CH-1:0] tone;
  logic [4:0]      ncnt;
  logic [16:0]     lfsr;
  logic [15:0]     ecnt;
  logic            env_step, env_restart, env_up, env_at_end;
  logic [1:0]      env_state, env_state_nxt;
  logic [4:0]      env_vol, env_vol_nxt;

  logic [7:0]       lane [N_CH];
  logic [MIX_W-1:0] mix_nxt;
`ifdef PSG_STEREO_EN
  logic [MIX_W-1:0] mix_l_nxt, mix_r_nxt;
`endif

  // Bus edge detect, address latch and register writes; R16 writes arm an envelope restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bdir_q    <= 1'b0;
      addr      <= 5'd0;
      noise_p   <= 5'd0;
      mixer     <= 8'hFF;
      env_p     <= 16'd0;
      env_shape <= 4'd0;
      env_pend  <= 1'b0;
`ifdef PSG_STEREO_EN
      pan       <= 8'hFF;
`endif
      for (int k = 0; k < N_CH; k++) begin
        tone_p[k] <= 12'd0;
        vol_r[k]  <= 5'd0;
      end
    end else begin
      bdir_q <= bus.bdir;
      if (env_restart) env_pend <= 1'b0;
      if (latch_stb) addr <= bus.di[4:0];
      if (wr_stb) begin
        for (int k = 0; k < N_CH; k++) begin
          if (addr == 5'(2*k))     tone_p[k][7:0]  <= bus.di;
          if (addr == 5'(2*k + 1)) tone_p[k][11:8] <= bus.di[3:0];
          if (addr == 5'(10 + k))  vol_r[k]        <= bus.di[4:0];
        end
        case (addr)
          5'd8:  noise_p     <= bus.di[4:0];
          5'd9:  mixer       <= bus.di;
          5'd14: env_p[7:0]  <= bus.di;
          5'd15: env_p[15:8] <= bus.di;
          5'd16: begin
            env_shape <= bus.di[3:0];
            env_pend  <= 1'b1;
          end
`ifdef PSG_STEREO_EN
          5'd17: pan <= bus.di;
`endif
          default: ;
        endcase
      end
    end
  end

  // Readback mux from the latched address; unimplemented locations read 0.
  always_comb begin
    rd = 8'h00;
    for (int k = 0; k < N_CH; k++) begin
      if (addr == 5'(2*k))     rd = tone_p[k][7:0];
      if (addr == 5'(2*k + 1)) rd = {4'h0, tone_p[k][11:8]};
      if (addr == 5'(10 + k))  rd = {3'b000, vol_r[k]};
    end
    case (addr)
      5'd8:  rd = {3'b000, noise_p};
      5'd9:  rd = mixer;
      5'd14: rd = env_p[7:0];
      5'd15: rd = env_p[15:8];
      5'd16: rd = {4'h0, env_shape};
`ifdef PSG_STEREO_EN
      5'd17: rd = pan;
`endif
      default: ;
    endcase
  end
  assign bus.dout_c = rd;

  assign tick     = bus.ce & (pcnt == PS_LAST);
  assign ntick    = tick & ntog;
  assign env_step = tick & (ecnt >= lim(env_p));

  // Prescaler: tick every PRESCALE CEs, ntick on every second tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      ntog <= 1'b0;
    end else if (bus.ce) begin
      pcnt <= (pcnt == PS_LAST) ? '0 : pcnt + 1'b1;
      if (tick) ntog <= ~ntog;
    end
  end

  // Tone dividers; a period below the running count wraps on the next tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone <= '0;
      for (int k = 0; k < N_CH; k++) tcnt[k] <= 12'd0;
    end else if (tick) begin
      for (int k = 0; k < N_CH; k++) begin
        if (16'(tcnt[k]) >= lim(16'(tone_p[k]))) begin
          tcnt[k] <= 12'd0;
          tone[k] <= ~tone[k];
        end else begin
          tcnt[k] <= tcnt[k] + 12'd1;
        end
      end
    end
  end

  // Noise divider and LFSR (taps 0 and 3 feed bit 16).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncnt <= 5'd0;
      lfsr <= 17'h00001;
    end else if (ntick) begin
      if (16'(ncnt) >= lim(16'(noise_p))) begin
        ncnt <= 5'd0;
        lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        ncnt <= ncnt + 5'd1;
      end
    end
  end

  // Envelope step divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ecnt <= 16'd0;
    else if (tick) ecnt <= env_step ? 16'd0 : ecnt + 16'd1;
  end

  assign env_restart = bus.ce & env_pend;
  assign env_up      = (env_state == ENV_UP);
  assign env_at_end  = env_up ? (env_vol == 5'd31) : (env_vol == 5'd0);

  // Envelope state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_state <= ENV_HOLD;
      env_vol   <= 5'd0;
    end else begin
      env_state <= env_state_nxt;
      env_vol   <= env_vol_nxt;
    end
  end

  // Envelope next state: restart beats a coincident step; shape decides end-of-ramp action.
  always_comb begin
    env_state_nxt = env_state;
    env_vol_nxt   = env_vol;
    if (env_restart) begin
      env_state_nxt = env_shape[2] ? ENV_UP : ENV_DOWN;
      env_vol_nxt   = env_shape[2] ? 5'd0 : 5'd31;
    end else if (env_step && (env_state != ENV_HOLD)) begin
      if (!env_at_end) begin
        env_vol_nxt = env_up ? env_vol + 5'd1 : env_vol - 5'd1;
      end else if (!env_shape[3]) begin
        env_state_nxt = ENV_HOLD;
        env_vol_nxt   = 5'd0;
      end else if (env_shape[0]) begin
        env_state_nxt = ENV_HOLD;
        env_vol_nxt   = env_shape[1] ? ~env_vol : env_vol;
      end else if (env_shape[1]) begin
        env_state_nxt = env_up ? ENV_DOWN : ENV_UP;
        env_vol_nxt   = env_up ? 5'd30 : 5'd1;
      end else begin
        env_vol_nxt = env_up ? 5'd0 : 5'd31;
      end
    end
  end

  // Per-channel gate, volume code, log lookup and lane sums.
  always_comb begin
    mix_nxt = '0;
`ifdef PSG_STEREO_EN
    mix_l_nxt = '0;
    mix_r_nxt = '0;
`endif
    for (int k = 0; k < N_CH; k++) begin
      lane[k] = 8'h00;
      if ((mixer[k] | tone[k]) & (mixer[4+k] | lfsr[0]))
        lane[k] = log_vol(vol_r[k][4] ? env_vol : {vol_r[k][3:0], vol_r[k][3]});
      mix_nxt = mix_nxt + MIX_W'(lane[k]);
`ifdef PSG_STEREO_EN
      if (pan[k])   mix_l_nxt = mix_l_nxt + MIX_W'(lane[k]);
      if (pan[4+k]) mix_r_nxt = mix_r_nxt + MIX_W'(lane[k]);
`endif
    end
  end

  // Output registers, updated every clock regardless of CE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_out <= '0;
      mix    <= '0;
      active <= '0;
`ifdef PSG_STEREO_EN
      mix_l  <= '0;
      mix_r  <= '0;
`endif
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        ch_out[8*k +: 8] <= lane[k];
        active[k]        <= ~(mixer[k] & mixer[4+k]);
      end
      mix <= mix_nxt;
`ifdef PSG_STEREO_EN
      mix_l <= mix_l_nxt;
      mix_r <= mix_r_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_psg_multi.sv
// tb_psg_multi: random and directed stimulus for psg_multi, checked every cycle against
// a behavioural model, plus hand-computed expectations from the register/audio rules.
`timescale 1ns/1ps
module tb_psg_multi;
  localparam int N_CH     = 3;
  localparam int PRESCALE = 8;
  localparam int MIX_W    = 10;
  localparam int LOG_TAB [32] = '{
    'h00, 'h01, 'h01, 'h02, 'h02, 'h03, 'h03, 'h04, 'h06, 'h07, 'h09, 'h0A, 'h0C, 'h0E, 'h11, 'h13,
    'h17, 'h1B, 'h20, 'h25, 'h2C, 'h35, 'h3E, 'h47, 'h54, 'h66, 'h77, 'h88, 'hA1, 'hC0, 'hE0, 'hFF};

  logic clk, rst;
  psg_multi_if bus ();
  logic [8*N_CH-1:0] ch_out;
  logic [MIX_W-1:0]  mix;
  logic [N_CH-1:0]   active;
`ifdef PSG_STEREO_EN
  logic [MIX_W-1:0]  mix_l, mix_r;
`endif

  psg_multi #(.N_CH(N_CH), .PRESCALE(PRESCALE), .MIX_W(MIX_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .ch_out (ch_out),
    .mix    (mix),
`ifdef PSG_STEREO_EN
    .mix_l  (mix_l),
    .mix_r  (mix_r),
`endif
    .active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  int ce_mode = 0;

  // Behavioural model state
  int m_tp [4], m_tc [4], m_vol [4];
  bit m_tone [4];
  int m_pc, m_np, m_nc, m_mixer, m_envp, m_shape, m_ec, m_ev, m_edir, m_addr, m_pan;
  bit m_ntog, m_pend, m_bprev;
  bit [16:0] m_lfsr;
  int e_ch, e_mix, e_act, e_mixl, e_mixr;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim_of(input int p);
    return (p == 0) ? 0 : p - 1;
  endfunction

  function automatic int m_code(input int k);
    bit tone_ok, noise_ok;
    int lvl;
    tone_ok  = (((m_mixer >> k) & 1) != 0) || m_tone[k];
    noise_ok = (((m_mixer >> (4 + k)) & 1) != 0) || m_lfsr[0];
    lvl = m_vol[k] & 15;
    if (!(tone_ok && noise_ok)) return 0;
    if ((m_vol[k] & 16) != 0) return m_ev;
    return lvl * 2 + (lvl >> 3);
  endfunction

  function automatic int m_read(input int a);
    int k;
    if (a < 8) begin
      k = a / 2;
      if (k >= N_CH) return 0;
      return (a % 2 == 1) ? ((m_tp[k] >> 8) & 15) : (m_tp[k] & 255);
    end
    if (a >= 10 && a <= 13) return (a - 10 < N_CH) ? m_vol[a - 10] : 0;
    case (a)
      8:  return m_np;
      9:  return m_mixer;
      14: return m_envp & 255;
      15: return (m_envp >> 8) & 255;
      16: return m_shape;
`ifdef PSG_STEREO_EN
      17: return m_pan;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic m_write(input int a, input int d);
    int k;
    if (a < 8) begin
      k = a / 2;
      if (k < N_CH) begin
        if (a % 2 == 1) m_tp[k] = (m_tp[k] & 'hFF) | ((d & 15) << 8);
        else            m_tp[k] = (m_tp[k] & 'hF00) | d;
      end
    end else if (a >= 10 && a <= 13) begin
      if (a - 10 < N_CH) m_vol[a - 10] = d & 31;
    end else begin
      case (a)
        8:  m_np = d & 31;
        9:  m_mixer = d;
        14: m_envp = (m_envp & 'hFF00) | d;
        15: m_envp = (m_envp & 'hFF) | (d << 8);
        16: begin m_shape = d & 15; m_pend = 1; end
`ifdef PSG_STEREO_EN
        17: m_pan = d;
`endif
        default: ;
      endcase
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_tp[k] = 0; m_tc[k] = 0; m_vol[k] = 0; m_tone[k] = 0;
    end
    m_pc = 0; m_np = 0; m_nc = 0; m_mixer = 'hFF; m_envp = 0; m_shape = 0; m_ec = 0;
    m_ev = 0; m_edir = 0; m_addr = 0; m_pan = 'hFF; m_ntog = 0; m_pend = 0; m_bprev = 0;
    m_lfsr = 17'h00001;
    e_ch = 0; e_mix = 0; e_act = 0; e_mixl = 0; e_mixr = 0;
  endtask

  // Envelope movement by one step, expressed as volume plus direction (0 = held).
  task automatic m_env_step();
    int nv;
    bit c, al, h;
    c = m_shape[3]; al = m_shape[1]; h = m_shape[0];
    if (m_edir == 0) return;
    nv = m_ev + m_edir;
    if (nv >= 0 && nv <= 31) m_ev = nv;
    else if (!c) begin m_ev = 0; m_edir = 0; end
    else if (h) begin m_ev = al ? 31 - m_ev : m_ev; m_edir = 0; end
    else if (al) begin m_edir = -m_edir; m_ev = m_ev + m_edir; end
    else m_ev = (m_edir > 0) ? 0 : 31;
  endtask

  task automatic m_step();
    int lv;
    bit tick, nt, step, restart, rise;
    e_ch = 0; e_mix = 0; e_act = 0; e_mixl = 0; e_mixr = 0;
    for (int k = 0; k < N_CH; k++) begin
      lv = LOG_TAB[m_code(k)];
      e_ch  = e_ch | (lv << (8 * k));
      e_mix = e_mix + lv;
      if (((m_pan >> k) & 1) != 0) e_mixl = e_mixl + lv;
      if (((m_pan >> (4 + k)) & 1) != 0) e_mixr = e_mixr + lv;
      if (((m_mixer >> k) & 1) == 0 || ((m_mixer >> (4 + k)) & 1) == 0) e_act = e_act | (1 << k);
    end
    if (bus.ce) begin
      restart = m_pend;
      m_pend = 0;
      tick = (m_pc == PRESCALE - 1);
      m_pc = tick ? 0 : m_pc + 1;
      nt = tick && m_ntog;
      if (tick) m_ntog = !m_ntog;
      if (tick) begin
        for (int k = 0; k < N_CH; k++) begin
          if (m_tc[k] >= lim_of(m_tp[k])) begin m_tc[k] = 0; m_tone[k] = !m_tone[k]; end
          else m_tc[k] = m_tc[k] + 1;
        end
      end
      if (nt) begin
        if (m_nc >= lim_of(m_np)) begin
          m_nc = 0;
          m_lfsr = {m_lfsr[0] ^ m_lfsr[3], m_lfsr[16:1]};
        end else m_nc = m_nc + 1;
      end
      step = tick && (m_ec >= lim_of(m_envp));
      if (tick) m_ec = step ? 0 : m_ec + 1;
      if (restart) begin
        m_ev   = m_shape[2] ? 0 : 31;
        m_edir = m_shape[2] ? 1 : -1;
      end else if (step) m_env_step();
    end
    rise = bus.bdir && !m_bprev;
    m_bprev = bus.bdir;
    if (rise && bus.bc)  m_addr = bus.di & 31;
    if (rise && !bus.bc) m_write(m_addr, bus.di);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else     m_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ch_out", int'(ch_out), e_ch);
      check("mix", int'(mix), e_mix);
      check("active", int'(active), e_act);
      check("dout", int'(bus.dout_c), m_read(m_addr));
`ifdef PSG_STEREO_EN
      check("mix_l", int'(mix_l), e_mixl);
      check("mix_r", int'(mix_r), e_mixr);
`endif
    end
  end

  task automatic cyc();
    @(negedge clk);
    case (ce_mode)
      0:       bus.ce = 1'b0;
      1:       bus.ce = 1'b1;
      default: bus.ce = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic set_addr(input int a);
    cyc(); bus.bdir = 1'b1; bus.bc = 1'b1; bus.di = 8'(a);
    cyc(); bus.bdir = 1'b0;
  endtask

  task automatic bus_write(input int a, input int d);
    set_addr(a);
    cyc(); bus.bdir = 1'b1; bus.bc = 1'b0; bus.di = 8'(d);
    cyc(); bus.bdir = 1'b0;
  endtask

  int trans, bad, prev, cnt, a, d;
  bit done;

  initial begin
    rst = 1'b1;
    bus.ce = 1'b0; bus.bdir = 1'b0; bus.bc = 1'b0; bus.di = 8'h00;
    repeat (3) cyc();
    chk_en = 1;
    cyc();
    check("reset ch_out", int'(ch_out), 0);
    check("reset mix", int'(mix), 0);
    check("reset active", int'(active), 0);
    rst = 1'b0;
    set_addr(9);
    cyc();
    check("reset R9 readback", int'(bus.dout_c), 'hFF);

    // Channel 0 tone, period 1: lane toggles 00/FF every PRESCALE clocks
    bus_write(0, 1); bus_write(9, 'hFE); bus_write(10, 'h0F);
    ce_mode = 1;
    repeat (2) cyc();
    check("active ch0 only", int'(active), 1);
    trans = 0; bad = 0; prev = int'(ch_out[7:0]);
    repeat (64) begin
      cyc();
      if (ch_out[7:0] != 8'h00 && ch_out[7:0] != 8'hFF) bad++;
      if (int'(ch_out[7:0]) != prev) trans++;
      prev = int'(ch_out[7:0]);
    end
    check("tone0 transitions in 64 clk", trans, 8);
    check("tone0 off-level samples", bad, 0);

    // Readback masking and ignored locations
    bus_write(1, 'hAB); set_addr(1); cyc();
    check("R1 hi readback", int'(bus.dout_c), 'h0B);
    bus_write(7, 'h05); set_addr(7); cyc();
    check("R7 absent channel", int'(bus.dout_c), 0);
    bus_write(20, 'h55); set_addr(20); cyc();
    check("R20 unimplemented", int'(bus.dout_c), 0);

    // Envelope up-then-hold-31 ramp
    ce_mode = 0;
    bus_write(9, 'hFF); bus_write(14, 1); bus_write(15, 0); bus_write(10, 'h10);
    bus_write(16, 'h0D);
    ce_mode = 1;
    bad = 0; prev = 0;
    repeat (300) begin
      cyc();
      if (int'(ch_out[7:0]) < prev) bad++;
      prev = int'(ch_out[7:0]);
    end
    check("env ramp monotonic", bad, 0);
    check("env ramp end", int'(ch_out[7:0]), 'hFF);
    repeat (40) cyc();
    check("env hold 31", int'(ch_out[7:0]), 'hFF);

    // Triangle: after the 31 step the next step shows 30
    bus_write(16, 'h0E);
    done = 0; cnt = 0;
    while (!done && cnt < 50) begin cyc(); cnt++; done = (ch_out[7:0] != 8'hFF); end
    check("tri restart seen", int'(done), 1);
    done = 0; cnt = 0;
    while (!done && cnt < 400) begin cyc(); cnt++; done = (ch_out[7:0] == 8'hFF); end
    check("tri reached 31", int'(done), 1);
    done = 0; cnt = 0;
    while (!done && cnt < 100) begin cyc(); cnt++; done = (ch_out[7:0] != 8'hFF); end
    check("tri left 31", int'(done), 1);
    check("tri step after 31", int'(ch_out[7:0]), 'hE0);

    // Rewrite R16 mid-ramp: restart waits for the next CE
    bus_write(16, 'h0D);
    repeat (120) cyc();
    ce_mode = 0;
    bus_write(16, 'h0D);
    repeat (3) cyc();
    check("pending restart without CE", int'(ch_out[7:0] != 8'h00), 1);
    ce_mode = 1;
    repeat (3) cyc();
    check("restart on next CE", int'(ch_out[7:0]), 0);

    // All channels fixed at full level
    bus_write(9, 'hFF); bus_write(10, 'h0F); bus_write(11, 'h0F); bus_write(12, 'h0F);
    repeat (2) cyc();
    check("full mix", int'(mix), 765);
    check("full lanes", int'(ch_out), 'hFFFFFF);

    // Randomised register traffic with random CE
    ce_mode = 2;
    repeat (80) begin
      a = $urandom_range(0, 23);
      d = $urandom_range(0, 255);
      if (a == 1 || a == 3 || a == 5 || a == 15) d = $urandom_range(0, 1);
      if (a == 14) d = $urandom_range(0, 7);
      bus_write(a, d);
      repeat ($urandom_range(0, 20)) cyc();
    end

    // Async reset mid-ramp, with a pending restart that must be discarded
    ce_mode = 1;
    bus_write(9, 'hFF); bus_write(10, 'h10); bus_write(16, 'h0D);
    repeat (100) cyc();
    ce_mode = 0;
    bus_write(16, 'h00);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst ch_out", int'(ch_out), 0);
    check("async rst mix", int'(mix), 0);
    check("async rst dout", int'(bus.dout_c), 0);
    repeat (2) cyc();
    rst = 1'b0;
    ce_mode = 1;
    bus_write(10, 'h10);
    repeat (20) cyc();
    check("restart discarded by reset", int'(ch_out[7:0]), 0);
    set_addr(9); cyc();
    check("R9 after async reset", int'(bus.dout_c), 'hFF);

    ce_mode = 2;
    repeat (60) cyc();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
